// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// Provides the FSM state enum, the zero-register specifier and the stall-need encodings.
package pipeline_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned REG_ZERO = 0;

    localparam logic [1:0] NEED_0 = 2'd0;
    localparam logic [1:0] NEED_1 = 2'd1;
    localparam logic [1:0] NEED_2 = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_need.sv
// Combinational register-match and stall-need decode for the ID stage.
// Keeps no state, so it can be reused if branch resolution moves to EX.
module hazard_need_decode
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_reg_write,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  ex_mem_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_branch,
    output logic [1:0]            need
);

    localparam logic [REG_ADDR_W-1:0] ZERO_SPEC = REG_ADDR_W'(REG_ZERO);

    logic m_ex;
    logic m_mem;

    always_comb begin
        m_ex  = (id_ex_rd != ZERO_SPEC) &&
                ((id_ex_rd == id_rs) || (id_uses_rt && (id_ex_rd == id_rt)));
        m_mem = (ex_mem_rd != ZERO_SPEC) &&
                ((ex_mem_rd == id_rs) || (id_uses_rt && (ex_mem_rd == id_rt)));
    end

    // Ordered priority: a branch waiting on an EX load outranks every other rule.
    always_comb begin
        need = NEED_0;
        if (id_branch && id_ex_mem_read && m_ex) begin
            need = NEED_2;
        end else if (id_branch && id_ex_reg_write && m_ex) begin
            need = NEED_1;
        end else if (id_branch && ex_mem_mem_read && m_mem) begin
            need = NEED_1;
        end else if (id_ex_mem_read && m_ex) begin
            need = NEED_1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard/stall controller: stall FSM, IF/ID flush and optional perf counters.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_count counter ports.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ID_EX_MemRead,
    input  logic                  ID_EX_RegWrite,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd,
    input  logic                  EX_MEM_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
    input  logic                  IF_ID_UsesRt,
    input  logic                  IF_ID_Branch,
    input  logic                  branch_taken,
    input  logic                  jump,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  ID_EX_bubble,
    output logic                  IF_ID_flush,
    output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
`endif
);

    logic [1:0] need;
    state_t     state;
    state_t     state_next;
    logic [1:0] cnt;
    logic [1:0] cnt_next;
    logic       stall;

    hazard_need_decode #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_need (
        .id_ex_mem_read  (ID_EX_MemRead),
        .id_ex_reg_write (ID_EX_RegWrite),
        .id_ex_rd        (ID_EX_RegisterRd),
        .ex_mem_mem_read (EX_MEM_MemRead),
        .ex_mem_rd       (EX_MEM_RegisterRd),
        .id_rs           (IF_ID_RegisterRs),
        .id_rt           (IF_ID_RegisterRt),
        .id_uses_rt      (IF_ID_UsesRt),
        .id_branch       (IF_ID_Branch),
        .need            (need)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        case (state)
            RUN: begin
                if (need != NEED_0) begin
                    stall = 1'b1;
                end
                if (need == NEED_2) begin
                    state_next = HOLD;
                    cnt_next   = 2'd1;
                end
            end
            HOLD: begin
                // Inputs are ignored here; the hazard is re-checked once back in RUN.
                stall = 1'b1;
                if (cnt <= 2'd1) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        if (rst_n) begin
            PC_write     = ~stall;
            IF_ID_write  = ~stall;
            ID_EX_bubble = stall;
            IF_ID_flush  = (jump || (IF_ID_Branch && branch_taken)) && !stall;
        end
        stall_active = ~PC_write;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!PC_write) begin
                stall_cycles <= stall_cycles + PERF_CNT_W'(1);
            end
            if (IF_ID_flush) begin
                flush_count <= flush_count + PERF_CNT_W'(1);
            end
        end
    end
`else
`endif

endmodule
